// File: rtl/prach_lane_pack.sv
// Buffers 3-lane PRACH beats and serialises each beat into three 32-bit lane words with frame marks.
// Optional build macro PRACH_LANE_PACK_DROP_CNT_EN adds the saturating drop_cnt output.
module prach_lane_pack #(
   parameter int DEPTH     = 8,
   parameter int FRAME_LEN = 1536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din_valid,
   input  logic [15:0] din_dp1 [3],
   input  logic [15:0] din_dp2 [3],
   input  logic [7:0]  din_chn,
   input  logic        sync_in,
   output logic [31:0] dout_data,
   output logic [1:0]  dout_lane,
   output logic [7:0]  dout_chn,
   output logic        dout_sync,
   output logic        dout_last,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        overflow,
   output logic        frame_err
`ifdef PRACH_LANE_PACK_DROP_CNT_EN
   ,
   output logic [15:0] drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FRAME_LEN);

   typedef struct packed {
      logic [2:0][15:0] dp1;
      logic [2:0][15:0] dp2;
      logic [7:0]       chn;
      logic             sync;
      logic             last;
   } beat_t;

   // Output stream: a word moves on dout_valid & dout_ready; dout_valid is purely
   // registered, and a presented word holds every field until it is taken.

   logic [FW-1:0] fcnt;
   logic          frame_in;
   logic          last_flag;

   beat_t         in_beat;
   beat_t         cap;
   logic          cap_valid;

   beat_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   occ;
   logic          full;
   logic          push;
   logic          pop;
   logic          xfer;

   beat_t         head;
   beat_t         next_head;
   beat_t         ld_beat;
   logic [1:0]    ld_lane;
   logic          load;

   assign last_flag = frame_in & (fcnt == FW'(FRAME_LEN - 1)) & ~sync_in;

   always_comb begin
      in_beat = '0;
      for (int i = 0; i < 3; i++) begin
         in_beat.dp1[i] = din_dp1[i];
         in_beat.dp2[i] = din_dp2[i];
      end
      in_beat.chn  = din_chn;
      in_beat.sync = sync_in;
      in_beat.last = last_flag;
   end

   // The capture stage counts toward occupancy so a beat is only accepted when
   // the FIFO is guaranteed to have room for it one cycle later.
   assign occ  = count + {{AW{1'b0}}, cap_valid};
   assign full = (occ == (AW+1)'(DEPTH));
   assign push = cap_valid;
   assign xfer = dout_valid & dout_ready;
   assign pop  = xfer & (dout_lane == 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt      <= '0;
         frame_in  <= 1'b0;
         frame_err <= 1'b0;
      end else if (din_valid) begin
         if (sync_in) begin
            if (frame_in && (fcnt != '0)) frame_err <= 1'b1;
            fcnt     <= FW'(1);
            frame_in <= 1'b1;
         end else if (last_flag) begin
            fcnt     <= '0;
            frame_in <= 1'b0;
         end else if (frame_in) begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_valid <= 1'b0;
         cap       <= '0;
         overflow  <= 1'b0;
`ifdef PRACH_LANE_PACK_DROP_CNT_EN
         drop_cnt  <= '0;
`endif
      end else begin
         cap_valid <= din_valid & ~full;
         if (din_valid && !full) cap <= in_beat;
         if (din_valid && full) begin
            overflow <= 1'b1;
`ifdef PRACH_LANE_PACK_DROP_CNT_EN
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign head      = mem[rd_ptr];
   assign next_head = mem[rd_ptr + AW'(1)];

   function automatic logic [31:0] lane_word(input beat_t b, input logic [1:0] l);
      case (l)
         2'd0:    lane_word = {b.dp2[0], b.dp1[0]};
         2'd1:    lane_word = {b.dp2[1], b.dp1[1]};
         default: lane_word = {b.dp2[2], b.dp1[2]};
      endcase
   endfunction

   // The head beat stays in the FIFO while its lanes are shown; it is only
   // released when lane 2 is taken, and the following beat loads in the same cycle.
   always_comb begin
      load    = 1'b0;
      ld_beat = head;
      ld_lane = 2'd0;
      if (!dout_valid) begin
         load = (count != '0);
      end else if (xfer) begin
         if (dout_lane != 2'd2) begin
            load    = 1'b1;
            ld_lane = dout_lane + 2'd1;
         end else if (count >= (AW+1)'(2)) begin
            load    = 1'b1;
            ld_beat = next_head;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_lane  <= '0;
         dout_chn   <= '0;
         dout_sync  <= 1'b0;
         dout_last  <= 1'b0;
      end else if (!dout_valid || xfer) begin
         dout_valid <= load;
         if (load) begin
            dout_data <= lane_word(ld_beat, ld_lane);
            dout_lane <= ld_lane;
            dout_chn  <= ld_beat.chn;
            dout_sync <= ld_beat.sync & (ld_lane == 2'd0);
            dout_last <= ld_beat.last & (ld_lane == 2'd2);
         end
      end
   end

endmodule

// File: tb/tb_prach_lane_pack.sv
// Self-checking bench for prach_lane_pack: directed scenarios plus randomized traffic
// against a beat-level reference model with an expected word queue.
`timescale 1ns/1ps
module tb_prach_lane_pack;
  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 4;
  localparam int W         = 44;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [15:0] din_dp1 [3];
  logic [15:0] din_dp2 [3];
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [31:0] dout_data;
  logic [1:0]  dout_lane;
  logic [7:0]  dout_chn;
  logic        dout_sync;
  logic        dout_last;
  logic        dout_valid;
  logic        dout_ready;
  logic        overflow;
  logic        frame_err;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  prach_lane_pack #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_dp1(din_dp1), .din_dp2(din_dp2),
    .din_chn(din_chn), .sync_in(sync_in), .dout_data(dout_data), .dout_lane(dout_lane),
    .dout_chn(dout_chn), .dout_sync(dout_sync), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .overflow(overflow),
    .frame_err(frame_err)
`ifdef PRACH_LANE_PACK_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

`ifndef PRACH_LANE_PACK_DROP_CNT_EN
  assign drop_cnt = '0;
`endif

  // expected word layout: {data[31:0], lane[1:0], chn[7:0], sync, last}
  logic [W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int held;
  bit f_in;
  int f_cnt;
  bit exp_ovf;
  bit exp_ferr;
  int exp_drops;
  int exp_dv = -1;
  bit prev_stall;
  logic [W-1:0] prev_obs;
  int words_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    held = 0; f_in = 0; f_cnt = 0;
    exp_ovf = 0; exp_ferr = 0; exp_drops = 0;
    prev_stall = 0; prev_obs = '0;
  endtask

  function automatic logic [W-1:0] mk_word(input int l, input bit lastf);
    logic [1:0] ln;
    ln = 2'(l);
    return {din_dp2[l], din_dp1[l], ln, din_chn, (sync_in && l == 0), (lastf && l == 2)};
  endfunction

  task automatic rand_beat(input bit s);
    for (int i = 0; i < 3; i++) begin
      din_dp1[i] = 16'($urandom_range(0, 65535));
      din_dp2[i] = 16'($urandom_range(0, 65535));
    end
    din_chn = 8'($urandom_range(0, 255));
    sync_in = s;
  endtask

  // one clock: check outputs at the falling edge, then account for what the rising edge did
  task automatic step();
    logic [W-1:0] obs;
    logic [W-1:0] w;
    bit xfer;
    bit pop;
    bit lastf;
    @(negedge clk);
    obs = {dout_data, dout_lane, dout_chn, dout_sync, dout_last};
    if (exp_dv >= 0) check("valid_timing", 64'(dout_valid), 64'(exp_dv));
    if (dout_valid) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("word", 64'(obs), 64'(exp_q[0]));
    end
    if (prev_stall) check("stall_hold", 64'({dout_valid, obs}), 64'({1'b1, prev_obs}));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("frame_err", 64'(frame_err), 64'(exp_ferr));
`ifdef PRACH_LANE_PACK_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif
    xfer = dout_valid && dout_ready;
    prev_stall = dout_valid && !dout_ready;
    prev_obs = obs;
    @(posedge clk);
    pop = 0;
    if (xfer && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      words_out++;
      pop = (w[11:10] == 2'd2);
    end
    if (din_valid) begin
      lastf = 0;
      if (sync_in) begin
        if (f_in && f_cnt != 0) exp_ferr = 1;
        f_in = 1; f_cnt = 1;
      end else if (f_in) begin
        if (f_cnt == FRAME_LEN - 1) begin
          lastf = 1; f_in = 0; f_cnt = 0;
        end else begin
          f_cnt++;
        end
      end
      if (held >= DEPTH) begin
        exp_ovf = 1;
        if (exp_drops < 65535) exp_drops++;
      end else begin
        held++;
        for (int l = 0; l < 3; l++) exp_q.push_back(mk_word(l, lastf));
      end
    end
    if (pop) held--;
    #1;
  endtask

  task automatic do_reset();
    din_valid = 0;
    sync_in = 0;
    #2 rst = 1;
    #1;
    check("rst_outputs", 64'({dout_valid, dout_data, dout_lane, dout_chn, dout_sync,
                              dout_last, overflow, frame_err, drop_cnt}), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; din_valid = 0; sync_in = 0; dout_ready = 0; din_chn = '0;
    for (int i = 0; i < 3; i++) begin din_dp1[i] = '0; din_dp2[i] = '0; end
    model_reset();
    words_out = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({dout_valid, dout_data, dout_lane, dout_chn, dout_sync,
                              dout_last, overflow, frame_err, drop_cnt}), 64'(0));
    @(posedge clk);
    #1 rst = 0;

    // single beat with fixed data and latency checks
    din_dp1[0] = 16'h0001; din_dp1[1] = 16'h0002; din_dp1[2] = 16'h0003;
    din_dp2[0] = 16'h0011; din_dp2[1] = 16'h0012; din_dp2[2] = 16'h0013;
    din_chn = 8'h05; sync_in = 1; din_valid = 1; dout_ready = 1;
    step();
    din_valid = 0; sync_in = 0;
    exp_dv = 0; step(); step();
    exp_dv = 1;
    #3 check("single_w0", 64'(dout_data), 64'(32'h00110001));
    step(); step(); step();
    exp_dv = 0; step();
    exp_dv = -1;

    // frame end marking, beats every third cycle
    do_reset();
    dout_ready = 1;
    for (int b = 0; b < 5; b++) begin
      rand_beat(b == 0);
      din_valid = 1; step();
      din_valid = 0; sync_in = 0; step(); step();
    end
    repeat (4) step();

    // backpressure: fill, drop the ninth, drain with stalls
    do_reset();
    dout_ready = 0;
    for (int b = 0; b < 9; b++) begin
      rand_beat(0);
      din_valid = 1; step();
    end
    din_valid = 0;
    step();
    check("bp_overflow", 64'(overflow), 64'(1));
    words_out = 0;
    for (int i = 0; i < 80; i++) begin
      dout_ready = (i % 2 == 1);
      step();
    end
    check("bp_words", 64'(words_out), 64'(24));

    // early sync truncates a frame
    do_reset();
    dout_ready = 1;
    for (int b = 0; b < 8; b++) begin
      rand_beat(b == 0 || b == 3);
      din_valid = 1; step();
      din_valid = 0; sync_in = 0; step(); step();
    end
    repeat (4) step();
    check("early_sync_err", 64'(frame_err), 64'(1));

    // randomized ready with full-rate then sparse input
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      dout_ready = 1'($urandom_range(0, 1));
      rand_beat($urandom_range(0, 7) == 0);
      din_valid = (i < 500) ? 1'b1 : ($urandom_range(0, 2) == 0);
      step();
    end
    din_valid = 0; sync_in = 0; dout_ready = 1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    repeat (4) step();
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    // async reset while lane 1 of a beat is presented with three beats held
    dout_ready = 0;
    for (int b = 0; b < 3; b++) begin
      rand_beat(0);
      din_valid = 1; step();
    end
    din_valid = 0;
    dout_ready = 1; step();
    dout_ready = 0;
    check("pre_rst_lane1", 64'({dout_valid, dout_lane}), 64'({1'b1, 2'd1}));
    do_reset();
    rand_beat(1);
    din_valid = 1; step();
    din_valid = 0; sync_in = 0;
    exp_dv = 0; step(); step();
    exp_dv = 1; dout_ready = 1; step(); step(); step();
    exp_dv = 0; step(); step();
    exp_dv = -1;
    check("post_rst_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
